kbd_event_ctrl: RTL and testbench

Memory-mapped keyboard event controller for the single-cycle RISC-V SoC. Captures each keyboard event (`keyCode` plus `shift` modifiers) on the rising edge of `dataReady` into a small FIFO, so keystrokes arriving while software is busy are not lost. The CPU pops events through a data register and reads fill level and overflow through a status register. The block also owns the 12-bit LED output register and raises a level interrupt while events are pending.

---
 rtl/kbd_event_ctrl.sv | 152 +++++++++++++++
 tb/tb_kbd_event_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl
//   Memory-mapped keyboard event controller. Each rising edge of dataReady
//   captures {shift, keyCode} into a small circular FIFO. Software pops events
//   through DATA, checks fill level and overflow through STATUS, and sets
//   enable / irq_en (or flushes the FIFO) through CTRL. The block also owns
//   the 12-bit LED register.
//
//   Register window (byte offsets from BASE, full 32-bit decode):
//     +0  STATUS  [0]=empty [1]=full [2]=overflow (W1C) [8 +: AW+1]=count
//     +4  DATA    [31]=valid [10:8]=shift [7:0]=keyCode; a read pops
//     +8  CTRL    [0]=enable [1]=irq_en [2]=flush (write-only strobe)
//     +12 LED     [11:0]
//
//   Ports:
//     clk_pix    system clock, rising edge
//     rst_n      asynchronous active-low reset
//     MemWrite   CPU store strobe
//     MemRead    CPU load strobe (qualifies the DATA pop)
//     dataAddr   CPU byte address
//     WriteData  CPU store data
//     ReadData   combinational read data
//     keyCode    scan code, valid while dataReady is high
//     dataReady  keyboard event level, synchronous to clk_pix
//     shift      modifier state, captured with keyCode
//     led        LED register output
//     irq        level interrupt: irq_en and FIFO not empty

module kbd_event_ctrl #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] BASE  = 32'h1C0
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] dataAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  keyCode,
  input  logic        dataReady,
  input  logic [2:0]  shift,
  output logic [11:0] led,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   count;
  logic          drQ;
  logic          enable;
  logic          irqEn;
  logic          overflow;
  logic [11:0]   ledReg;

  logic selStatus, selData, selCtrl, selLed;
  logic empty, full;
  logic pushReq, popReq, flush;
  logic doPush, doPop, overflowSet, overflowClr;

  assign selStatus = (dataAddr == BASE);
  assign selData   = (dataAddr == BASE + 32'd4);
  assign selCtrl   = (dataAddr == BASE + 32'd8);
  assign selLed    = (dataAddr == BASE + 32'd12);

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  assign pushReq = dataReady & ~drQ & enable;
  assign popReq  = MemRead & selData & ~empty;
  assign flush   = MemWrite & selCtrl & WriteData[2];

  // Flush wins over both sides. A push into a full FIFO only succeeds when a
  // pop frees the head slot on the same edge; otherwise it is dropped and
  // flagged as overflow.
  assign doPush      = pushReq & ~flush & (~full | popReq);
  assign doPop       = popReq & ~flush;
  assign overflowSet = pushReq & ~flush & full & ~popReq;
  assign overflowClr = MemWrite & selStatus & WriteData[2];

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      drQ      <= 1'b0;
      enable   <= 1'b1;
      irqEn    <= 1'b0;
      overflow <= 1'b0;
      ledReg   <= '0;
    end else begin
      drQ <= dataReady;

      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (doPush) wrPtr <= wrPtr + 1'b1;
        if (doPop)  rdPtr <= rdPtr + 1'b1;
        unique case ({doPush, doPop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      // Set beats a same-cycle W1C so no overflow event is silently lost.
      if (flush)            overflow <= 1'b0;
      else if (overflowSet) overflow <= 1'b1;
      else if (overflowClr) overflow <= 1'b0;

      if (MemWrite && selCtrl) begin
        enable <= WriteData[0];
        irqEn  <= WriteData[1];
      end

      if (MemWrite && selLed) ledReg <= WriteData[11:0];
    end
  end

  // Storage is deliberately not reset; count/pointers define what is valid.
  always_ff @(posedge clk_pix) begin
    if (doPush) mem[wrPtr] <= {shift, keyCode};
  end

  always_comb begin
    ReadData = '0;
    if (selStatus) begin
      ReadData[0]          = empty;
      ReadData[1]          = full;
      ReadData[2]          = overflow;
      ReadData[8 +: AW+1]  = count;
    end else if (selData) begin
      if (!empty) ReadData = {1'b1, 20'b0, mem[rdPtr]};
    end else if (selCtrl) begin
      ReadData = {30'b0, irqEn, enable};
    end else if (selLed) begin
      ReadData = {20'b0, ledReg};
    end
  end

  assign led = ledReg;
  assign irq = irqEn & ~empty;

  logic unusedWriteData;
  assign unusedWriteData = ^{WriteData[31:12], WriteData[3]};

endmodule

// File: tb/tb_kbd_event_ctrl.sv
module tb_kbd_event_ctrl;

  localparam logic [31:0] A_STATUS = 32'h1C0;
  localparam logic [31:0] A_DATA   = 32'h1C4;
  localparam logic [31:0] A_CTRL   = 32'h1C8;
  localparam logic [31:0] A_LED    = 32'h1CC;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic        MemWrite, MemRead;
  logic [31:0] dataAddr, WriteData, ReadData;
  logic [7:0]  keyCode;
  logic        dataReady;
  logic [2:0]  shift;
  logic [11:0] led;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  kbd_event_ctrl #(.DEPTH(8), .BASE(32'h1C0)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .MemWrite(MemWrite), .MemRead(MemRead),
    .dataAddr(dataAddr), .WriteData(WriteData), .ReadData(ReadData),
    .keyCode(keyCode), .dataReady(dataReady), .shift(shift), .led(led), .irq(irq)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    MemRead  = 1'b0;
    dataAddr = addr;
    #1 data = ReadData;
  endtask

  task automatic cpuRead(input logic [31:0] addr, output logic [31:0] data);
    dataAddr = addr;
    MemRead  = 1'b1;
    #1 data = ReadData;
    tick();
    MemRead = 1'b0;
  endtask

  task automatic cpuWrite(input logic [31:0] addr, input logic [31:0] wdata);
    dataAddr  = addr;
    WriteData = wdata;
    MemWrite  = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic keyEvent(input logic [7:0] code, input logic [2:0] sh);
    keyCode   = code;
    shift     = sh;
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; MemWrite = 0; MemRead = 0; dataAddr = 0; WriteData = 0;
    keyCode = 0; dataReady = 0; shift = 0;
    repeat (3) @(posedge clk_pix);
    #1 rst_n = 1'b1;
    tick();

    // reset state
    peek(A_STATUS, rd); checkEq("rst_status", rd, 32'h1);
    peek(A_DATA, rd);   checkEq("rst_data", rd, 32'h0);
    peek(A_CTRL, rd);   checkEq("rst_ctrl", rd, 32'h1);
    checkEq("rst_led", {20'b0, led}, 32'h0);
    checkEq("rst_irq", {31'b0, irq}, 32'h0);

    // three events in order
    keyEvent(8'h1C, 3'b001);
    keyEvent(8'h32, 3'b000);
    keyEvent(8'h21, 3'b100);
    peek(A_STATUS, rd); checkEq("three_status", rd, 32'h300);
    peek(32'h1D0, rd);  checkEq("unmapped_read", rd, 32'h0);
    peek(32'h11C0, rd); checkEq("alias_read", rd, 32'h0);
    cpuRead(A_DATA, rd); checkEq("pop0", rd, 32'h8000011C);
    cpuRead(A_DATA, rd); checkEq("pop1", rd, 32'h80000032);
    cpuRead(A_DATA, rd); checkEq("pop2", rd, 32'h80000421);
    peek(A_STATUS, rd); checkEq("drained_status", rd, 32'h1);
    cpuRead(A_DATA, rd); checkEq("pop_empty", rd, 32'h0);
    peek(A_STATUS, rd); checkEq("pop_empty_status", rd, 32'h1);

    // held dataReady gives one entry
    keyCode = 8'h55; shift = 3'b000; dataReady = 1'b1;
    repeat (10) tick();
    dataReady = 1'b0;
    tick();
    peek(A_STATUS, rd); checkEq("held_status", rd, 32'h100);
    cpuRead(A_DATA, rd); checkEq("held_pop", rd, 32'h80000055);
    peek(A_STATUS, rd); checkEq("held_drained", rd, 32'h1);

    // overflow: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) keyEvent(8'h10 + 8'(i), 3'b000);
    peek(A_STATUS, rd); checkEq("ovf_status", rd, 32'h806);
    for (int i = 0; i < 8; i++) begin
      cpuRead(A_DATA, rd);
      checkEq($sformatf("ovf_pop%0d", i), rd, 32'h80000010 + 32'(i));
    end
    peek(A_STATUS, rd); checkEq("ovf_empty_status", rd, 32'h5);
    cpuWrite(A_STATUS, 32'h4);
    peek(A_STATUS, rd); checkEq("w1c_status", rd, 32'h1);

    // full + simultaneous push and pop
    for (int i = 0; i < 8; i++) keyEvent(8'h40 + 8'(i), 3'b000);
    peek(A_STATUS, rd); checkEq("full_status", rd, 32'h802);
    keyCode = 8'h77; shift = 3'b010; dataReady = 1'b1;
    dataAddr = A_DATA; MemRead = 1'b1;
    #1 rd = ReadData; checkEq("pushpop_head", rd, 32'h80000040);
    tick();
    MemRead = 1'b0; dataReady = 1'b0;
    tick();
    peek(A_STATUS, rd); checkEq("pushpop_status", rd, 32'h802);
    for (int i = 1; i < 8; i++) begin
      cpuRead(A_DATA, rd);
      checkEq($sformatf("pushpop_pop%0d", i), rd, 32'h80000040 + 32'(i));
    end
    cpuRead(A_DATA, rd); checkEq("pushpop_last", rd, 32'h80000277);

    // overflow set beats same-cycle W1C
    for (int i = 0; i < 8; i++) keyEvent(8'h60 + 8'(i), 3'b000);
    keyCode = 8'h99; dataReady = 1'b1;
    cpuWrite(A_STATUS, 32'h4);
    dataReady = 1'b0;
    tick();
    peek(A_STATUS, rd); checkEq("set_beats_w1c", rd, 32'h806);
    cpuWrite(A_CTRL, 32'h5);
    peek(A_STATUS, rd); checkEq("flush_full", rd, 32'h1);

    // flush drops a same-cycle push without overflow
    keyCode = 8'h33; dataReady = 1'b1;
    cpuWrite(A_CTRL, 32'h5);
    dataReady = 1'b0;
    tick();
    peek(A_STATUS, rd); checkEq("flush_push", rd, 32'h1);

    // irq, disable, flush, LED
    keyEvent(8'h2A, 3'b000);
    checkEq("irq_masked", {31'b0, irq}, 32'h0);
    cpuWrite(A_CTRL, 32'h2);
    checkEq("irq_on", {31'b0, irq}, 32'h1);
    peek(A_CTRL, rd); checkEq("ctrl_read", rd, 32'h2);
    keyEvent(8'h2B, 3'b000);
    peek(A_STATUS, rd); checkEq("disabled_status", rd, 32'h100);
    cpuWrite(A_CTRL, 32'h6);
    peek(A_STATUS, rd); checkEq("flush_status", rd, 32'h1);
    checkEq("irq_off", {31'b0, irq}, 32'h0);
    peek(A_CTRL, rd); checkEq("ctrl_no_flush", rd, 32'h2);
    cpuWrite(32'h1D0, 32'hFFF);
    checkEq("unmapped_write", {20'b0, led}, 32'h0);
    cpuWrite(A_LED, 32'hFFFF_FABC);
    checkEq("led_out", {20'b0, led}, 32'hABC);
    peek(A_LED, rd); checkEq("led_read", rd, 32'hABC);

    // reset mid-operation
    cpuWrite(A_CTRL, 32'h3);
    keyEvent(8'h01, 3'b000);
    keyEvent(8'h02, 3'b000);
    checkEq("pre_rst_irq", {31'b0, irq}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    peek(A_STATUS, rd); checkEq("mid_rst_status", rd, 32'h1);
    checkEq("mid_rst_led", {20'b0, led}, 32'h0);
    checkEq("mid_rst_irq", {31'b0, irq}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    peek(A_CTRL, rd); checkEq("mid_rst_ctrl", rd, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
